extnet_pool: RTL and testbench

- Parametrised 2x2/stride-2 pooling stage for the multi-unit fixed-point feature stream produced by the ExtNet conv layers.
- Sits between conv layers or after the last layer; generalises unit count, fixed-point format and reduction mode (max or average).
- Consumes one raster-ordered pixel per clock with window counters (vcnt/hcnt incl. blanking).
- Emits one pooled feature vector per 2x2 block with halved coordinates.

---
 rtl/extnet_pool.sv | 187 ++++++++++++++++++
 tb/tb_extnet_pool.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/extnet_pool.sv
// extnet_pool: 2x2 / stride-2 max or average pooling over a raster-ordered, multi-unit fixed-point stream.
// Build option: define POOL_RELU_EN to force negative pooled channels to zero at the output register.
module extnet_pool #(
  parameter int WIDTH     = 8,
  parameter int HEIGHT    = 8,
  parameter int W_WIDTH   = 10,
  parameter int W_HEIGHT  = 10,
  parameter int UNITS     = 12,
  parameter int INT_BITW  = 5,
  parameter int FRAC_BITW = 8,
  parameter int MODE      = 0,
  localparam int FIXED_BITW = INT_BITW + FRAC_BITW,
  localparam int H_BITW     = $clog2(W_WIDTH),
  localparam int V_BITW     = $clog2(W_HEIGHT),
  localparam int PIX_BITW   = FIXED_BITW * UNITS
) (
  input  logic                clock,
  input  logic                rst,
  input  logic                in_enable,
  input  logic [0:PIX_BITW-1] in_pixels,
  input  logic [V_BITW-1:0]   in_vcnt,
  input  logic [H_BITW-1:0]   in_hcnt,
  output logic                out_enable,
  output logic [0:PIX_BITW-1] out_pixels,
  output logic [V_BITW-1:0]   out_vcnt,
  output logic [H_BITW-1:0]   out_hcnt
);

  localparam int PAIR_BITW = FIXED_BITW + 1;
  localparam int SUM_BITW  = FIXED_BITW + 2;
  localparam int LB_DEPTH  = WIDTH / 2;
  localparam int LB_AW     = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam int LB_WORD   = UNITS * PAIR_BITW;

  localparam logic [31:0] WIDTH_U    = 32'(WIDTH);
  localparam logic [31:0] HEIGHT_U   = 32'(HEIGHT);
  localparam logic [31:0] LB_DEPTH_U = 32'(LB_DEPTH);

  logic [0:PIX_BITW-1] h_hold_q, h_hold_d;
  logic                h_ok_q, h_ok_d;
  logic                row_ok_q, row_ok_d;
  logic                v0_seen_q, v0_seen_d;
  logic                out_enable_q, out_enable_d;
  logic [0:PIX_BITW-1] out_pixels_q, out_pixels_d;
  logic [V_BITW-1:0]   out_vcnt_q, out_vcnt_d;
  logic [H_BITW-1:0]   out_hcnt_q, out_hcnt_d;

  logic                accept;
  logic                v_odd;
  logic                h_odd;
  logic                pair_fire;
  logic                out_fire;
  logic [H_BITW-1:0]   lb_col;
  logic                lb_col_ok;
  logic [LB_AW-1:0]    lb_addr;
  logic                lb_we;
  logic                lb_re;

  logic [LB_WORD-1:0]  lb_mem [LB_DEPTH];
  logic [LB_WORD-1:0]  lb_rd_q;
  logic [LB_WORD-1:0]  pair_word;
  logic [0:PIX_BITW-1] result_word;

  assign accept    = in_enable && (32'(in_vcnt) < HEIGHT_U) && (32'(in_hcnt) < WIDTH_U);
  assign v_odd     = in_vcnt[0];
  assign h_odd     = in_hcnt[0];
  assign lb_col    = in_hcnt >> 1;
  assign lb_col_ok = 32'(lb_col) < LB_DEPTH_U;
  assign lb_addr   = LB_AW'(lb_col);
  assign pair_fire = accept && h_odd && h_ok_q;
  assign out_fire  = pair_fire && v_odd && row_ok_q;
  // Even rows only write and odd rows only read, so the two ports never collide.
  assign lb_we     = pair_fire && !v_odd && lb_col_ok;
  assign lb_re     = accept && !h_odd && v_odd && lb_col_ok;

  // Per-channel arithmetic: horizontal pair, then vertical combine with the buffered upper pair.
  for (genvar gi = 0; gi < UNITS; gi++) begin : g_ch
    logic signed [FIXED_BITW-1:0] hold_val;
    logic signed [FIXED_BITW-1:0] pix_val;
    logic signed [PAIR_BITW-1:0]  pair_val;
    logic signed [PAIR_BITW-1:0]  top_val;
    logic signed [FIXED_BITW-1:0] res_val;
    logic signed [FIXED_BITW-1:0] res_act;

    assign hold_val = h_hold_q[gi*FIXED_BITW +: FIXED_BITW];
    assign pix_val  = in_pixels[gi*FIXED_BITW +: FIXED_BITW];
    assign top_val  = lb_rd_q[gi*PAIR_BITW +: PAIR_BITW];

    if (MODE == 1) begin : g_avg
      logic signed [SUM_BITW-1:0] sum_val;
      logic                       unused_bits;

      assign pair_val    = {hold_val[FIXED_BITW-1], hold_val} + {pix_val[FIXED_BITW-1], pix_val};
      // +2 then drop two LSBs: divide by four, rounding half up.
      assign sum_val     = {top_val[PAIR_BITW-1], top_val} + {pair_val[PAIR_BITW-1], pair_val}
                           + SUM_BITW'(2);
      assign res_val     = sum_val[SUM_BITW-1:2];
      assign unused_bits = ^sum_val[1:0];
    end else begin : g_max
      assign pair_val = (hold_val > pix_val) ? {hold_val[FIXED_BITW-1], hold_val}
                                             : {pix_val[FIXED_BITW-1], pix_val};
      assign res_val  = (top_val > pair_val) ? top_val[FIXED_BITW-1:0]
                                             : pair_val[FIXED_BITW-1:0];
    end

`ifdef POOL_RELU_EN
    assign res_act = res_val[FIXED_BITW-1] ? '0 : res_val;
`else
    assign res_act = res_val;
`endif

    assign pair_word[gi*PAIR_BITW +: PAIR_BITW]      = pair_val;
    assign result_word[gi*FIXED_BITW +: FIXED_BITW] = res_act;
  end

  always_comb begin
    h_hold_d     = h_hold_q;
    h_ok_d       = h_ok_q;
    row_ok_d     = row_ok_q;
    v0_seen_d    = v0_seen_q;
    out_enable_d = out_fire;
    out_pixels_d = out_pixels_q;
    out_vcnt_d   = out_vcnt_q;
    out_hcnt_d   = out_hcnt_q;

    if (accept) begin
      v0_seen_d = (in_vcnt == '0);
      if (!h_odd) begin
        h_hold_d = in_pixels;
        h_ok_d   = 1'b1;
      end else begin
        h_ok_d   = 1'b0;
      end
      // First accepted pixel of row 0 starts a new frame: the buffered row is stale.
      if ((in_vcnt == '0) && !v0_seen_q) begin
        row_ok_d = 1'b0;
      end
      if (lb_we && (lb_col == '0)) begin
        row_ok_d = 1'b1;
      end
    end

    if (out_fire) begin
      out_pixels_d = result_word;
      out_vcnt_d   = in_vcnt >> 1;
      out_hcnt_d   = in_hcnt >> 1;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      h_hold_q     <= '0;
      h_ok_q       <= 1'b0;
      row_ok_q     <= 1'b0;
      v0_seen_q    <= 1'b0;
      out_enable_q <= 1'b0;
      out_pixels_q <= '0;
      out_vcnt_q   <= '0;
      out_hcnt_q   <= '0;
    end else begin
      h_hold_q     <= h_hold_d;
      h_ok_q       <= h_ok_d;
      row_ok_q     <= row_ok_d;
      v0_seen_q    <= v0_seen_d;
      out_enable_q <= out_enable_d;
      out_pixels_q <= out_pixels_d;
      out_vcnt_q   <= out_vcnt_d;
      out_hcnt_q   <= out_hcnt_d;
    end
  end

  // Line buffer: no reset so it maps onto block RAM with a registered read.
  always_ff @(posedge clock) begin
    if (lb_we) begin
      lb_mem[lb_addr] <= pair_word;
    end
    if (lb_re) begin
      lb_rd_q <= lb_mem[lb_addr];
    end
  end

  assign out_enable = out_enable_q;
  assign out_pixels = out_pixels_q;
  assign out_vcnt   = out_vcnt_q;
  assign out_hcnt   = out_hcnt_q;

endmodule

// File: tb/tb_extnet_pool.sv
// Bench for extnet_pool: four instances (max/avg x 4x2/5x3 active area) share one pixel stream
// and are compared every cycle against a frame-image reference model.
module tb_extnet_pool;

  localparam int UN = 2;
  localparam int FB = 13;
  localparam int PW = FB * UN;
  localparam int VB = 2;
  localparam int HB = 3;
  localparam int NI = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_enable = 1'b0;
  logic [0:PW-1] in_pixels = '0;
  logic [VB-1:0] in_vcnt = '0;
  logic [HB-1:0] in_hcnt = '0;

  logic          oe [NI];
  logic [0:PW-1] op [NI];
  logic [VB-1:0] ov [NI];
  logic [HB-1:0] oh [NI];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    extnet_pool #(
      .WIDTH     ((gi < 2) ? 4 : 5),
      .HEIGHT    ((gi < 2) ? 2 : 3),
      .W_WIDTH   (8),
      .W_HEIGHT  (4),
      .UNITS     (UN),
      .INT_BITW  (5),
      .FRAC_BITW (8),
      .MODE      (gi % 2)
    ) u_dut (
      .clock      (clk),
      .rst        (rst),
      .in_enable  (in_enable),
      .in_pixels  (in_pixels),
      .in_vcnt    (in_vcnt),
      .in_hcnt    (in_hcnt),
      .out_enable (oe[gi]),
      .out_pixels (op[gi]),
      .out_vcnt   (ov[gi]),
      .out_hcnt   (oh[gi])
    );
  end

  // ---------------- reference model ----------------
  int            pix [4][8][UN];
  bit            vld [NI][4][8];
  bit            exp_en [NI];
  logic [0:PW-1] exp_px [NI];
  int            exp_v [NI];
  int            exp_h [NI];

  typedef struct {
    int px [4];
    int exp_max;
    int exp_avg;
  } vec_t;
  vec_t tbl [10];
  int   blk_vals [4];
  bit   blk_on = 1'b0;

  function automatic int inst_w(input int i);
    return (i < 2) ? 4 : 5;
  endfunction

  function automatic int inst_h(input int i);
    return (i < 2) ? 2 : 3;
  endfunction

  function automatic int act(input int x);
`ifdef POOL_RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  function automatic int chan(input logic [0:PW-1] p, input int u);
    logic signed [FB-1:0] t;
    t = p[u*FB +: FB];
    return int'(t);
  endfunction

  function automatic int pool(input int mode, input int a, input int b, input int c, input int d);
    int r;
    if (mode == 0) begin
      r = a;
      if (b > r) r = b;
      if (c > r) r = c;
      if (d > r) r = d;
    end else begin
      r = (a + b + c + d + 2) >>> 2;
    end
    return act(r);
  endfunction

  function automatic logic [0:PW-1] rand_px();
    logic [0:PW-1] p;
    p = '0;
    for (int u = 0; u < UN; u++) p[u*FB +: FB] = FB'($urandom_range(0, (1 << FB) - 1));
    return p;
  endfunction

  task automatic clear_frame();
    for (int i = 0; i < NI; i++)
      for (int v = 0; v < 4; v++)
        for (int h = 0; h < 8; h++) vld[i][v][h] = 1'b0;
  endtask

  task automatic reset_model();
    clear_frame();
    for (int i = 0; i < NI; i++) begin
      exp_en[i] = 1'b0;
      exp_px[i] = '0;
      exp_v[i]  = 0;
      exp_h[i]  = 0;
    end
  endtask

  task automatic chk(input string name, input int i, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h", name, i, got, want);
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < NI; i++) begin
      chk("out_enable", i, 64'(oe[i]), 64'(exp_en[i]));
      chk("out_pixels", i, 64'(op[i]), 64'(exp_px[i]));
      chk("out_vcnt", i, 64'(ov[i]), 64'(exp_v[i]));
      chk("out_hcnt", i, 64'(oh[i]), 64'(exp_h[i]));
    end
  endtask

  // Drive one cycle, update the model, then sample 1 time unit after the edge.
  task automatic step(input int v, input int h, input bit en, input logic [0:PW-1] px);
    logic [FB-1:0] t;
    in_enable = en;
    in_vcnt   = VB'(v);
    in_hcnt   = HB'(h);
    in_pixels = px;
    if (en) for (int u = 0; u < UN; u++) pix[v][h][u] = chan(px, u);
    for (int i = 0; i < NI; i++) begin
      exp_en[i] = 1'b0;
      if (en && v < inst_h(i) && h < inst_w(i)) begin
        vld[i][v][h] = 1'b1;
        if ((v % 2 == 1) && (h % 2 == 1) && vld[i][v-1][h-1] && vld[i][v-1][h] && vld[i][v][h-1]) begin
          exp_en[i] = 1'b1;
          exp_v[i]  = v / 2;
          exp_h[i]  = h / 2;
          for (int u = 0; u < UN; u++) begin
            t = FB'(pool(i % 2, pix[v-1][h-1][u], pix[v-1][h][u], pix[v][h-1][u], pix[v][h][u]));
            exp_px[i][u*FB +: FB] = t;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("rst_out_enable", i, 64'(oe[i]), 64'(0));
      chk("rst_out_pixels", i, 64'(op[i]), 64'(0));
      chk("rst_out_vcnt", i, 64'(ov[i]), 64'(0));
      chk("rst_out_hcnt", i, 64'(oh[i]), 64'(0));
    end
    rst = 1'b0;
    reset_model();
    #1;
  endtask

  task automatic frame(input int idle_pct, input int rst_v, input int rst_h, input int drop_v, input int drop_h);
    logic [0:PW-1] px;
    int            idx;
    clear_frame();
    for (int v = 0; v < 4; v++) begin
      for (int h = 0; h < 8; h++) begin
        for (int k = 0; k < 3 && int'($urandom_range(0, 99)) < idle_pct; k++)
          step(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), 1'b0, rand_px());
        if (v == rst_v && h == rst_h) async_reset();
        px = rand_px();
        if (blk_on && v < 2 && (h == 2 || h == 3)) begin
          idx = v * 2 + (h - 2);
          px[0 +: FB]  = FB'(blk_vals[idx]);
          px[FB +: FB] = FB'(blk_vals[3 - idx]);
        end
        step(v, h, !(v == drop_v && h == drop_h), px);
      end
    end
  endtask

  // Example rows from the design notes, checked against hand-computed results.
  task automatic plan_frame();
    int            img [2][4];
    logic [0:PW-1] px;
    img[0] = '{1, 5, -3, 2};
    img[1] = '{4, 0, -1, -7};
    clear_frame();
    for (int v = 0; v < 4; v++) begin
      for (int h = 0; h < 8; h++) begin
        px = rand_px();
        if (v < 2 && h < 4) begin
          px[0 +: FB]  = FB'(img[v][h] * 256);
          px[FB +: FB] = FB'(img[v][h] * 256);
        end
        step(v, h, 1'b1, px);
        if (v == 1 && h == 1) begin
          chk("plan_max_blk0", 0, 64'(chan(op[0], 0)), 64'(act(1280)));
          chk("plan_avg_blk0", 1, 64'(chan(op[1], 0)), 64'(act(640)));
        end
        if (v == 1 && h == 3) begin
          chk("plan_max_blk1", 0, 64'(chan(op[0], 0)), 64'(act(512)));
          chk("plan_avg_blk1", 1, 64'(chan(op[1], 0)), 64'(act(-576)));
        end
      end
    end
  endtask

  task automatic set_vec(input int k, input int a, input int b, input int c, input int d,
                         input int m, input int av);
    tbl[k].px[0]   = a;
    tbl[k].px[1]   = b;
    tbl[k].px[2]   = c;
    tbl[k].px[3]   = d;
    tbl[k].exp_max = m;
    tbl[k].exp_avg = av;
  endtask

  initial begin
    set_vec(0, 256, 1280, 1024, 0, 1280, 640);
    set_vec(1, -768, 512, -256, -1792, 512, -576);
    set_vec(2, 1, 0, 0, 0, 1, 0);
    set_vec(3, 2, 0, 0, 0, 2, 1);
    set_vec(4, -256, -512, -768, -1024, -256, -640);
    set_vec(5, 4095, 4095, 4095, 4095, 4095, 4095);
    set_vec(6, -4096, -4096, -4096, -4096, -4096, -4096);
    set_vec(7, 4095, -4096, 0, 1, 4095, 0);
    set_vec(8, 3, 3, 3, 3, 3, 3);
    set_vec(9, -1, -1, -1, -2, -1, -1);

    reset_model();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;

    plan_frame();

    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < 4; j++) blk_vals[j] = tbl[k].px[j];
      blk_on = 1'b1;
      frame(0, -1, -1, -1, -1);
      blk_on = 1'b0;
      for (int i = 0; i < NI; i++) begin
        chk("tbl_unit0", i, 64'(chan(op[i], 0)), 64'(act((i % 2 == 0) ? tbl[k].exp_max : tbl[k].exp_avg)));
        chk("tbl_unit1", i, 64'(chan(op[i], 1)), 64'(act((i % 2 == 0) ? tbl[k].exp_max : tbl[k].exp_avg)));
        chk("tbl_vcnt", i, 64'(ov[i]), 64'(0));
        chk("tbl_hcnt", i, 64'(oh[i]), 64'(1));
      end
    end

    frame(0, -1, -1, 1, 3);
    frame(0, -1, -1, -1, -1);
    frame(20, 1, 1, -1, -1);
    frame(0, -1, -1, -1, -1);

    for (int f = 0; f < 20; f++) frame(30, -1, -1, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
